fixed_weight_loc_sched: RTL
===========================

FIXED_WEIGHT_LOC_SCHED -- requirements
Module: fixed_weight_loc_sched

Interface
REQ-001 Parameter M, default 15, width of a location / random candidate word.
REQ-002 Parameter N, default 17669, vector length; valid locations are 0..N-1.
REQ-003 Parameter WEIGHT, default 66, number of distinct locations to produce.
REQ-004 Parameter LOG_WEIGHT, default clog2(WEIGHT), width of location index.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse; begins a generation run; accepted only in IDLE.
REQ-008 abort  input  1  cancels a run in any state.
REQ-009 rnd_in  input  M  candidate word from the PRNG/XOF stream.
REQ-010 rnd_valid  input  1  rnd_in valid.
REQ-011 rnd_ready  output  1  block accepts rnd_in this cycle.
REQ-012 loc_out  output  M  accepted location, for the one-generator memory writer.
REQ-013 loc_addr  output  LOG_WEIGHT  index of loc_out within the location set.
REQ-014 loc_wr  output  1  one-cycle strobe: loc_out/loc_addr valid.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse: WEIGHT distinct locations delivered.
REQ-017 rej_cnt  output  16  candidates rejected as >= N in current/last run (saturating).
REQ-018 dup_cnt  output  16  candidates rejected as duplicates in current/last run (saturating).

Function
REQ-019 States IDLE, FETCH, CHECK, WRITE, DONE; internal WEIGHT x M location buffer, count register (accepted so far), scan index idx, candidate register cand.
REQ-020 IDLE: start=1 -> count=0, idx=0, rej_cnt=0, dup_cnt=0, next state FETCH; start outside IDLE ignored.
REQ-021 FETCH: rnd_ready=1 combinationally; on rnd_valid&rnd_ready, cand<=rnd_in.
REQ-022 FETCH handshake with rnd_in>=N: stay FETCH, rej_cnt+1; word consumed.
REQ-023 FETCH handshake with rnd_in<N: count==0 -> WRITE; else idx=0, -> CHECK.
REQ-024 rnd_ready SHALL be 0 in all states other than FETCH; no word consumed outside FETCH.
REQ-025 CHECK: one buffer entry compared per cycle; buf[idx]==cand -> dup_cnt+1, -> FETCH; else idx==count-1 -> WRITE; else idx+1.
REQ-026 WRITE: buf[count]<=cand; loc_wr=1, loc_addr=count, loc_out=cand for exactly this cycle; count+1.
REQ-027 WRITE with count==WEIGHT-1 (last location) -> DONE; else -> FETCH.
REQ-028 DONE: done=1 for one cycle, -> IDLE; count retains WEIGHT.
REQ-029 Accepted candidate latency: count==0 -> loc_wr 1 cycle after handshake; otherwise count+1 cycles after handshake.
REQ-030 All delivered locations in one run SHALL be pairwise distinct and < N; loc_addr strictly increases 0..WEIGHT-1.
REQ-031 abort=1 in any state -> IDLE next cycle, no done, no loc_wr that cycle; abort has priority over start and rnd_valid.
REQ-032 rej_cnt/dup_cnt saturate at 16'hFFFF; hold value in IDLE until next start.
REQ-033 Comparison >= N is unsigned on full M bits; rnd_in=N is rejected, N-1 accepted.

Reset
REQ-034 rst=1 -> state IDLE, count=0, idx=0, rej_cnt=0, dup_cnt=0, rnd_ready=0, loc_wr=0, done=0, busy=0, loc_out=0, loc_addr=0; buffer contents undefined.
REQ-035 rst mid-run overrides all inputs; no done or loc_wr issued after reset assertion.

Verification
REQ-036 WEIGHT=4, N=100, stream 5,17,42,99 with rnd_valid always 1 -> loc_wr at addr 0..3 with 5,17,42,99; done one cycle after last loc_wr; rej_cnt=0, dup_cnt=0.
REQ-037 Stream 100,32767,7,... -> first two consumed and rejected, rej_cnt=2, first loc_out=7 at addr 0.
REQ-038 Stream 5,5,5,8,... -> loc 5 at addr 0, two duplicates, dup_cnt=2, loc 8 at addr 1 after CHECK.
REQ-039 rnd_valid toggled randomly, random stream, default params -> 66 distinct values <N, done once, rnd_ready only in FETCH.
REQ-040 abort asserted in CHECK after 3 accepts -> busy=0 next cycle, no done; new start restarts at loc_addr 0 with counters cleared.
REQ-041 rst asserted during WRITE -> loc_wr=0, busy=0 next cycle; start accepted afterwards.

Source files
------------

// File: rtl/fixed_weight_loc_sched.sv
// rtl/fixed_weight_loc_sched.sv - fixed-weight location scheduler: draws WEIGHT distinct locations < N
// from a candidate stream, rejecting out-of-range words and duplicates.
module fixed_weight_loc_sched #(
    parameter int M          = 15,
    parameter int N          = 17669,
    parameter int WEIGHT     = 66,
    parameter int LOG_WEIGHT = $clog2(WEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [M-1:0]          rnd_in,
    input  logic                  rnd_valid,
    output logic                  rnd_ready,
    output logic [M-1:0]          loc_out,
    output logic [LOG_WEIGHT-1:0] loc_addr,
    output logic                  loc_wr,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           rej_cnt,
    output logic [15:0]           dup_cnt
);

    // count must be able to hold WEIGHT itself after the last write
    localparam int CW = $clog2(WEIGHT + 1);
    localparam logic [M-1:0]  N_M  = M'(N);
    localparam logic [CW-1:0] LAST = CW'(WEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_WRITE,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [M-1:0]   cand_q, cand_d;
    logic [15:0]    rej_q, rej_d;
    logic [15:0]    dup_q, dup_d;
    logic           buf_we;
    logic           hit;
    logic [M-1:0]   loc_buf_q [WEIGHT];

    assign hit     = (loc_buf_q[idx_q[LOG_WEIGHT-1:0]] == cand_q);
    assign busy    = (state_q != S_IDLE);
    assign rej_cnt = rej_q;
    assign dup_cnt = dup_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        cand_d    = cand_q;
        rej_d     = rej_q;
        dup_d     = dup_q;
        buf_we    = 1'b0;
        rnd_ready = 1'b0;
        loc_wr    = 1'b0;
        done      = 1'b0;
        loc_out   = '0;
        loc_addr  = '0;

        // abort and reset win over everything: no handshake, no strobes this cycle
        if (rst || abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        count_d = '0;
                        idx_d   = '0;
                        rej_d   = '0;
                        dup_d   = '0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    rnd_ready = 1'b1;
                    if (rnd_valid) begin
                        cand_d = rnd_in;
                        if (rnd_in >= N_M) begin
                            rej_d = (rej_q == 16'hFFFF) ? rej_q : rej_q + 16'd1;
                        end else if (count_q == '0) begin
                            state_d = S_WRITE;
                        end else begin
                            idx_d   = '0;
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (hit) begin
                        dup_d   = (dup_q == 16'hFFFF) ? dup_q : dup_q + 16'd1;
                        state_d = S_FETCH;
                    end else if (idx_q == count_q - 1'b1) begin
                        state_d = S_WRITE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    buf_we   = 1'b1;
                    loc_wr   = 1'b1;
                    loc_addr = count_q[LOG_WEIGHT-1:0];
                    loc_out  = cand_q;
                    count_d  = count_q + 1'b1;
                    state_d  = (count_q == LAST) ? S_DONE : S_FETCH;
                end
                S_DONE: begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            cand_q  <= '0;
            rej_q   <= '0;
            dup_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            cand_q  <= cand_d;
            rej_q   <= rej_d;
            dup_q   <= dup_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            loc_buf_q[count_q[LOG_WEIGHT-1:0]] <= cand_q;
        end
    end

endmodule
